// File: rtl/reg_share_arbiter.sv
// Round-robin arbiter that serialises LOAD/SET/CLEAR/TOGGLE requests
// onto one shared WIDTH-bit register, with an optional post-commit cooldown.
module reg_share_arbiter #(
  parameter int               N_REQ       = 4,
  parameter int               WIDTH       = 8,
  parameter int               COOL_CYCLES = 2,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req,
  input  logic [2*N_REQ-1:0]     op,
  input  logic [N_REQ*WIDTH-1:0] wdata,
  output logic [N_REQ-1:0]       grant,
  output logic [N_REQ-1:0]       ack,
  output logic [WIDTH-1:0]       q,
  output logic                   busy
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = $clog2(COOL_CYCLES + 2);
  localparam logic [CW-1:0] COOL_LAST =
    CW'((COOL_CYCLES > 0) ? COOL_CYCLES - 1 : 0);
  localparam logic [PW-1:0] PTR_LAST = PW'(N_REQ - 1);

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    COMMIT,
    COOL
  } state_e;

  typedef enum logic [1:0] {
    OP_LOAD,
    OP_SET,
    OP_CLEAR,
    OP_TOGGLE
  } op_e;

  state_e           state_q, state_d;
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [PW-1:0]    win_q, win_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [N_REQ-1:0] ack_q, ack_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [PW-1:0]    pick;
  logic             found;
  logic [PW-1:0]    ptr_next;

  function automatic logic [N_REQ-1:0] onehot(input logic [PW-1:0] i);
    onehot    = '0;
    onehot[i] = 1'b1;
  endfunction

  // First set request at or after the pointer, wrapping around.
  always_comb begin
    pick  = ptr_q;
    found = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!found && req[(int'(ptr_q) + k) % N_REQ]) begin
        found = 1'b1;
        pick  = PW'((int'(ptr_q) + k) % N_REQ);
      end
    end
  end

  assign ptr_next = (win_q == PTR_LAST) ? '0 : win_q + 1'b1;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    grant_d = grant_q;
    ack_d   = '0;
    q_d     = q_q;
    op_d    = op_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          win_d   = pick;
          grant_d = onehot(pick);
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (req[win_q]) begin
          op_d    = op[2*int'(win_q) +: 2];
          data_d  = wdata[int'(win_q)*WIDTH +: WIDTH];
          state_d = COMMIT;
        end else begin
          grant_d = '0;
          state_d = IDLE;
        end
      end
      COMMIT: begin
        unique case (op_q)
          OP_LOAD:   q_d = data_q;
          OP_SET:    q_d = '1;
          OP_CLEAR:  q_d = '0;
          OP_TOGGLE: q_d = q_q ^ data_q;
          default:   q_d = q_q;
        endcase
        ack_d   = onehot(win_q);
        grant_d = '0;
        ptr_d   = ptr_next;
        cnt_d   = '0;
        state_d = (COOL_CYCLES > 0) ? COOL : IDLE;
      end
      COOL: begin
        if (cnt_q == COOL_LAST) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      win_q   <= '0;
      grant_q <= '0;
      ack_q   <= '0;
      q_q     <= RESET_VALUE;
      op_q    <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      grant_q <= grant_d;
      ack_q   <= ack_d;
      q_q     <= q_d;
      op_q    <= op_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
    end
  end

  assign grant = grant_q;
  assign ack   = ack_q;
  assign q     = q_q;
  assign busy  = (state_q != IDLE);

endmodule

// File: tb/tb_reg_share_arbiter.sv
// Scoreboard bench for reg_share_arbiter: expected ack/q pairs are queued
// as requests are raised and matched when the ack pulse appears.
module tb_reg_share_arbiter;

  localparam logic [1:0] LOAD   = 2'b00;
  localparam logic [1:0] SET    = 2'b01;
  localparam logic [1:0] CLEAR  = 2'b10;
  localparam logic [1:0] TOGGLE = 2'b11;

  logic        clock;
  logic        reset;
  logic [3:0]  req;
  logic [7:0]  op;
  logic [31:0] wdata;
  logic [3:0]  grant;
  logic [3:0]  ack;
  logic [7:0]  q;
  logic        busy;

  typedef struct packed {
    logic [3:0] ack;
    logic [7:0] q;
  } exp_t;

  exp_t sb[$];
  int   vectors;
  int   miscompares;
  int   cyc;

  reg_share_arbiter #(
    .N_REQ(4),
    .WIDTH(8),
    .COOL_CYCLES(2),
    .RESET_VALUE(8'h00)
  ) dut (
    .clock(clock),
    .reset(reset),
    .req(req),
    .op(op),
    .wdata(wdata),
    .grant(grant),
    .ack(ack),
    .q(q),
    .busy(busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic await_ack(input int budget, output bit got);
    got = 1'b0;
    for (int n = 0; n < budget; n++) begin
      if (ack != 4'b0) begin
        got = 1'b1;
        return;
      end
      tick();
    end
    if (ack != 4'b0) got = 1'b1;
  endtask

  task automatic wait_idle();
    for (int n = 0; n < 20; n++) begin
      if (!busy) return;
      tick();
    end
    vectors++;
    miscompares++;
    $display("FAIL idle_timeout: busy=%b want 0", busy);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req   = '0;
    op    = '0;
    wdata = '0;
    tick();
    tick();
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      vectors++;
      if (q !== 8'h00 || grant !== 4'b0 || ack !== 4'b0 || busy !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_state c%0d: q=%h g=%b a=%b b=%b want 00/0000/0000/0",
                 i, q, grant, ack, busy);
      end
      tick();
    end
  endtask

  task automatic test_single_load();
    exp_t e;
    wait_idle();
    req        = 4'b0001;
    op[1:0]    = LOAD;
    wdata[7:0] = 8'hA5;
    sb.push_back('{ack: 4'b0001, q: 8'hA5});
    tick();
    vectors++;
    if (grant !== 4'b0001 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL load_c1: g=%b b=%b want 0001/1", grant, busy);
    end
    tick();
    vectors++;
    if (grant !== 4'b0001 || ack !== 4'b0) begin
      miscompares++;
      $display("FAIL load_c2: g=%b a=%b want 0001/0000", grant, ack);
    end
    tick();
    vectors++;
    e = sb.pop_front();
    if (ack !== e.ack || q !== e.q || grant !== 4'b0) begin
      miscompares++;
      $display("FAIL load_c3: a=%b q=%h g=%b want %b/%h/0000",
               ack, q, grant, e.ack, e.q);
    end
    req = '0;
    tick();
    vectors++;
    if (busy !== 1'b1 || ack !== 4'b0) begin
      miscompares++;
      $display("FAIL load_c4: b=%b a=%b want 1/0000", busy, ack);
    end
    tick();
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL load_c5_idle: b=%b want 0", busy);
    end
  endtask

  task automatic test_round_robin();
    exp_t e;
    bit   got;
    int   last;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    op    = '0;
    wdata = 32'h44332211;
    sb.push_back('{ack: 4'b0001, q: 8'h11});
    sb.push_back('{ack: 4'b0010, q: 8'h22});
    sb.push_back('{ack: 4'b0100, q: 8'h33});
    sb.push_back('{ack: 4'b1000, q: 8'h44});
    sb.push_back('{ack: 4'b0001, q: 8'h11});
    req  = 4'b1111;
    last = -1;
    for (int k = 0; k < 5; k++) begin
      await_ack(12, got);
      vectors++;
      if (!got || sb.size() == 0) begin
        miscompares++;
        $display("FAIL rr_ack%0d: got=%0d want ack", k, got);
      end else begin
        e = sb.pop_front();
        if (ack !== e.ack || q !== e.q) begin
          miscompares++;
          $display("FAIL rr_ack%0d: a=%b q=%h want %b/%h",
                   k, ack, q, e.ack, e.q);
        end
      end
      if (last >= 0) begin
        vectors++;
        if (cyc - last != 5) begin
          miscompares++;
          $display("FAIL rr_gap%0d: %0d cycles want 5", k, cyc - last);
        end
      end
      last = cyc;
      if (k == 4) req = '0;
      tick();
    end
  endtask

  task automatic do_op(input int idx, input logic [1:0] o,
                       input logic [7:0] d, input logic [7:0] exp_q);
    exp_t       e;
    bit         got;
    logic [3:0] oh;
    oh = 4'b0001 << idx;
    wait_idle();
    req              = oh;
    op[2*idx +: 2]   = o;
    wdata[8*idx +: 8] = d;
    sb.push_back('{ack: oh, q: exp_q});
    for (int n = 0; n < 4; n++) begin
      if (grant != 4'b0) break;
      tick();
    end
    vectors++;
    if (grant !== oh) begin
      miscompares++;
      $display("FAIL op_grant: g=%b want %b", grant, oh);
    end
    tick();
    op[2*idx +: 2]    = ~o;
    wdata[8*idx +: 8] = ~d;
    await_ack(4, got);
    vectors++;
    e = sb.pop_front();
    if (!got || ack !== e.ack || q !== e.q) begin
      miscompares++;
      $display("FAIL op_%0d: a=%b q=%h want %b/%h", o, ack, q, e.ack, e.q);
    end
    req = '0;
    tick();
  endtask

  task automatic test_opcodes();
    do_op(2, LOAD,   8'hF0, 8'hF0);
    do_op(2, TOGGLE, 8'hFF, 8'h0F);
    do_op(2, SET,    8'h00, 8'hFF);
    do_op(2, CLEAR,  8'hAA, 8'h00);
    do_op(2, LOAD,   8'h3C, 8'h3C);
    do_op(2, TOGGLE, 8'h5A, 8'h66);
  endtask

  task automatic test_abort();
    exp_t e;
    bit   got;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    do_op(0, LOAD, 8'h77, 8'h77);
    wait_idle();
    op[3:2]     = LOAD;
    wdata[15:8] = 8'h99;
    req         = 4'b0010;
    tick();
    vectors++;
    if (grant !== 4'b0010) begin
      miscompares++;
      $display("FAIL abort_grant: g=%b want 0010", grant);
    end
    req = '0;
    tick();
    vectors++;
    if (grant !== 4'b0 || ack !== 4'b0 || busy !== 1'b0 || q !== 8'h77) begin
      miscompares++;
      $display("FAIL abort_after: g=%b a=%b b=%b q=%h want 0000/0000/0/77",
               grant, ack, busy, q);
    end
    op[1:0]    = LOAD;
    wdata[7:0] = 8'h01;
    sb.push_back('{ack: 4'b0010, q: 8'h99});
    req = 4'b0011;
    tick();
    vectors++;
    if (grant !== 4'b0010) begin
      miscompares++;
      $display("FAIL abort_ptr: g=%b want 0010", grant);
    end
    await_ack(4, got);
    vectors++;
    e = sb.pop_front();
    if (!got || ack !== e.ack || q !== e.q) begin
      miscompares++;
      $display("FAIL abort_retry: a=%b q=%h want %b/%h", ack, q, e.ack, e.q);
    end
    req = '0;
    tick();
  endtask

  task automatic test_reset_mid_commit();
    exp_t e;
    bit   got;
    wait_idle();
    op[1:0]    = LOAD;
    wdata[7:0] = 8'h5A;
    req        = 4'b0001;
    for (int n = 0; n < 4; n++) begin
      if (grant != 4'b0) break;
      tick();
    end
    tick();
    vectors++;
    if (grant !== 4'b0001 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL rstc_commit: g=%b b=%b want 0001/1", grant, busy);
    end
    reset = 1'b1;
    req   = '0;
    tick();
    reset = 1'b0;
    vectors++;
    if (q !== 8'h00 || ack !== 4'b0 || grant !== 4'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL rstc_state: q=%h a=%b g=%b b=%b want 00/0000/0000/0",
               q, ack, grant, busy);
    end
    op          = '0;
    wdata[15:8] = 8'hC3;
    wdata[31:24] = 8'hEE;
    sb.push_back('{ack: 4'b0010, q: 8'hC3});
    req = 4'b1010;
    tick();
    vectors++;
    if (grant !== 4'b0010) begin
      miscompares++;
      $display("FAIL rstc_ptr: g=%b want 0010", grant);
    end
    await_ack(4, got);
    vectors++;
    e = sb.pop_front();
    if (!got || ack !== e.ack || q !== e.q) begin
      miscompares++;
      $display("FAIL rstc_op: a=%b q=%h want %b/%h", ack, q, e.ack, e.q);
    end
    req = '0;
    tick();
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL sb_drain: %0d left want 0", sb.size());
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    cyc         = 0;
    reset       = 1'b1;
    req         = '0;
    op          = '0;
    wdata       = '0;
    test_reset();
    test_single_load();
    test_round_robin();
    test_opcodes();
    test_abort();
    test_reset_mid_commit();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
